// File: rtl/dram_arbiter_pkg.sv
// Shared types for the two-requester DRAM lane arbiter.
//   NUM_LANES   : number of byte lanes per transaction
//   lane_addr_t : per-lane 64-bit byte addresses
//   lane_data_t : per-lane read bytes
//   arb_state_t : arbiter FSM state
package dram_arbiter_pkg;

  localparam int NUM_LANES = 8;

  typedef logic [NUM_LANES-1:0][63:0] lane_addr_t;
  typedef logic [NUM_LANES-1:0][7:0]  lane_data_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Bundle of every requester-side and DRAM-side signal of the arbiter.
//   slave  : arbiter view (requests/DRAM returns in; grants/done/DRAM command out)
//   master : environment view (requesters plus the DRAM model)
//
// Handshake: a requester holds rqN_en != 0 until it sees rqN_gnt, which pulses
// for exactly one cycle in the same cycle the request is latched. The arbiter
// then owns the DRAM command and holds it stable until every enabled lane has
// strobed dram_valid; one cycle later rqN_done pulses with rq_rdata valid.
// There is no back-pressure on dram_valid or on rqN_done.
interface dram_arbiter_if;
  import dram_arbiter_pkg::*;

  logic [NUM_LANES-1:0] rq0_en;
  logic                 rq0_rdwr;
  lane_addr_t           rq0_addr;
  logic [63:0]          rq0_data;
  logic [NUM_LANES-1:0] rq1_en;
  logic                 rq1_rdwr;
  lane_addr_t           rq1_addr;
  logic [63:0]          rq1_data;
  logic                 rq0_gnt;
  logic                 rq1_gnt;
  logic                 rq0_done;
  logic                 rq1_done;
  lane_data_t           rq_rdata;
  logic [NUM_LANES-1:0] dram_en;
  logic                 dram_rdwr;
  lane_addr_t           dram_addr;
  logic [63:0]          dram_wdata;
  lane_data_t           dram_rdata;
  logic [NUM_LANES-1:0] dram_valid;
  arb_state_t           dbg_state;

  modport slave (
    input  rq0_en, rq0_rdwr, rq0_addr, rq0_data,
    input  rq1_en, rq1_rdwr, rq1_addr, rq1_data,
    input  dram_rdata, dram_valid,
    output rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq_rdata,
    output dram_en, dram_rdwr, dram_addr, dram_wdata,
    output dbg_state
  );

  modport master (
    output rq0_en, rq0_rdwr, rq0_addr, rq0_data,
    output rq1_en, rq1_rdwr, rq1_addr, rq1_data,
    output dram_rdata, dram_valid,
    input  rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq_rdata,
    input  dram_en, dram_rdwr, dram_addr, dram_wdata,
    input  dbg_state
  );

endinterface

// File: rtl/dram_arbiter.sv
// Two-requester round-robin arbiter in front of an 8-lane DRAM port.
// A granted request is latched, replayed to the DRAM while BUSY, and per-lane
// read bytes are collected until every enabled lane has returned.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : dram_arbiter_if.slave (requesters, DRAM command/return, debug state)
module dram_arbiter
  import dram_arbiter_pkg::*;
(
  input logic           clk,
  input logic           reset,
  dram_arbiter_if.slave bus
);

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic                 r_owner;   // requester currently being served
  logic                 r_last;    // requester granted most recently
  logic [NUM_LANES-1:0] r_mask;
  logic [NUM_LANES-1:0] r_ret;
  logic                 r_rdwr;
  lane_addr_t           r_addr;
  logic [63:0]          r_wdata;
  lane_data_t           r_cap;     // bytes collected during the transaction
  lane_data_t           r_rdata;   // presented result, only changes at completion
  logic                 r_done0;
  logic                 r_done1;

  logic                 w_req0;
  logic                 w_req1;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic [NUM_LANES-1:0] w_hit;
  logic                 w_complete;

  assign w_req0     = |bus.rq0_en;
  assign w_req1     = |bus.rq1_en;
  assign w_hit      = bus.dram_valid & r_mask;
  // Lanes returning this very cycle count toward completion.
  assign w_complete = (r_state == ST_BUSY) && ((r_ret | w_hit) == r_mask);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt0 || w_gnt1) w_next_state = ST_BUSY;
      ST_BUSY: if (w_complete)       w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs. On a tie the requester not granted last wins; r_last
  // resets to 1 so requester 0 wins the first tie.
  always_comb begin
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    bus.dram_en    = '0;
    bus.dram_rdwr  = 1'b0;
    bus.dram_addr  = '0;
    bus.dram_wdata = '0;
    if (r_state == ST_IDLE && !reset) begin
      w_gnt0 = w_req0 && (!w_req1 || r_last);
      w_gnt1 = w_req1 && (!w_req0 || !r_last);
    end
    if (r_state == ST_BUSY) begin
      bus.dram_en    = r_mask;
      bus.dram_rdwr  = r_rdwr;
      bus.dram_addr  = r_addr;
      bus.dram_wdata = r_wdata;
    end
  end

  assign bus.rq0_gnt   = w_gnt0;
  assign bus.rq1_gnt   = w_gnt1;
  assign bus.rq0_done  = r_done0;
  assign bus.rq1_done  = r_done1;
  assign bus.rq_rdata  = r_rdata;
  assign bus.dbg_state = r_state;

  // Request latch and lane collection. Grants only occur in IDLE and
  // collection only in BUSY, so the two branches never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_mask  <= '0;
      r_ret   <= '0;
      r_rdwr  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cap   <= '0;
      r_rdata <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_gnt0 || w_gnt1) begin
        r_owner <= w_gnt1;
        r_last  <= w_gnt1;
        r_mask  <= w_gnt1 ? bus.rq1_en   : bus.rq0_en;
        r_rdwr  <= w_gnt1 ? bus.rq1_rdwr : bus.rq0_rdwr;
        r_addr  <= w_gnt1 ? bus.rq1_addr : bus.rq0_addr;
        r_wdata <= w_gnt1 ? bus.rq1_data : bus.rq0_data;
        r_ret   <= '0;
        // Cleared so unenabled lanes present 0 in the result.
        r_cap   <= '0;
      end else if (r_state == ST_BUSY) begin
        r_ret <= r_ret | w_hit;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (w_hit[i]) r_cap[i] <= bus.dram_rdata[i];
        end
        if (w_complete) begin
          r_done0 <= !r_owner;
          r_done1 <= r_owner;
          for (int i = 0; i < NUM_LANES; i++) begin
            r_rdata[i] <= w_hit[i] ? bus.dram_rdata[i] : r_cap[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed transactions, a behavioural
// DRAM whose read byte is a fixed function of the lane address, and a
// scoreboard of expected completions (owner + read data) popped on done.
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  localparam int W = 66;  // {check_rdata, owner, rdata[63:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dram_arbiter_if bus ();

  dram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- DRAM model ----------------
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) bus.dram_rdata[i] = mem_byte(bus.dram_addr[i]);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_gnt0 = 0, n_gnt1 = 0, n_done0 = 0, n_done1 = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rdata(input logic [63:0] base, input logic [7:0] en);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (en[i]) r[i*8 +: 8] = mem_byte(base + 64'(i));
    return r;
  endfunction

  task automatic push_exp(input logic chk_rd, input logic owner, input logic [63:0] rd);
    exp_q.push_back({chk_rd, owner, rd});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.rq0_gnt)  n_gnt0++;
    if (bus.rq1_gnt)  n_gnt1++;
    if (bus.rq0_done) n_done0++;
    if (bus.rq1_done) n_done1++;
    if (bus.rq0_done || bus.rq1_done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", {62'd0, bus.rq1_done, bus.rq0_done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_owner", {62'd0, bus.rq1_done, bus.rq0_done}, e[64] ? 64'd2 : 64'd1);
        if (e[65]) chk("rq_rdata", bus.rq_rdata, e[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input int n, input logic [7:0] en, input logic rdwr,
                           input logic [63:0] base, input logic [63:0] data);
    lane_addr_t a;
    for (int i = 0; i < NUM_LANES; i++) a[i] = base + 64'(i);
    if (n == 0) begin
      bus.rq0_en = en; bus.rq0_rdwr = rdwr; bus.rq0_addr = a; bus.rq0_data = data;
    end else begin
      bus.rq1_en = en; bus.rq1_rdwr = rdwr; bus.rq1_addr = a; bus.rq1_data = data;
    end
  endtask

  task automatic chk_grants(input string tag, input logic g0, input logic g1);
    chk({tag, "_gnt"}, {62'd0, bus.rq1_gnt, bus.rq0_gnt}, {62'd0, g1, g0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.rq0_en = '0; bus.rq0_rdwr = 1'b0; bus.rq0_addr = '0; bus.rq0_data = '0;
    bus.rq1_en = '0; bus.rq1_rdwr = 1'b0; bus.rq1_addr = '0; bus.rq1_data = '0;
    bus.dram_valid = '0;
    repeat (3) tick();
    sample();
    chk("rst_dram_en", 64'(bus.dram_en), 64'd0);
    chk("rst_outs", {60'd0, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_done, bus.rq1_done}, 64'd0);
    chk("rst_rdata", bus.rq_rdata, 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));

    // Tie in first IDLE cycle after reset, then re-tie after both served.
    tick();
    reset = 1'b0;
    drive_req(0, 8'hFF, 1'b0, 64'h100, 64'h1111);
    drive_req(1, 8'hFF, 1'b0, 64'h200, 64'h2222);
    sample();
    chk_grants("tie1", 1'b1, 1'b0);
    push_exp(1'b1, 1'b0, exp_rdata(64'h100, 8'hFF));
    push_exp(1'b1, 1'b1, exp_rdata(64'h200, 8'hFF));
    tick();
    bus.rq0_en = '0; bus.dram_valid = 8'hFF;
    sample();
    chk_grants("tie1_wait", 1'b0, 1'b0);
    chk("tie1_state", 64'(bus.dbg_state), 64'(ST_BUSY));
    chk("tie1_addr7", bus.dram_addr[7], 64'h107);
    tick();
    bus.dram_valid = '0;
    sample();
    chk_grants("tie1_handoff", 1'b0, 1'b1);
    chk("handoff_dram_en", 64'(bus.dram_en), 64'd0);
    tick();
    bus.rq1_en = '0; bus.dram_valid = 8'hFF;
    sample();
    chk("rq1_dram_addr0", bus.dram_addr[0], 64'h200);
    tick();
    bus.dram_valid = '0;
    tick();
    drive_req(0, 8'h0F, 1'b0, 64'h300, 64'h0);
    drive_req(1, 8'hF0, 1'b0, 64'h400, 64'h0);
    sample();
    chk_grants("tie2", 1'b1, 1'b0);
    push_exp(1'b1, 1'b0, exp_rdata(64'h300, 8'h0F));
    push_exp(1'b1, 1'b1, exp_rdata(64'h400, 8'hF0));
    tick();
    bus.rq0_en = '0; bus.dram_valid = 8'h0F;
    tick();
    bus.dram_valid = '0;
    sample();
    chk_grants("tie2_handoff", 1'b0, 1'b1);
    tick();
    bus.rq1_en = '0; bus.dram_valid = 8'hF0;
    tick();
    bus.dram_valid = '0;
    tick();

    // Full-lane read, DRAM returns two cycles after grant.
    drive_req(0, 8'hFF, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF);
    sample();
    chk_grants("rd_full", 1'b1, 1'b0);
    push_exp(1'b1, 1'b0, exp_rdata(64'h0, 8'hFF));
    tick();
    bus.rq0_en = '0;
    sample();
    chk_grants("rd_full_pulse", 1'b0, 1'b0);
    chk("rd_full_wdata", bus.dram_wdata, 64'h0123_4567_89AB_CDEF);
    chk("rd_full_rdwr", 64'(bus.dram_rdwr), 64'd0);
    tick();
    bus.dram_valid = 8'hFF;
    sample();
    chk("rd_full_early_done", 64'(bus.rq0_done), 64'd0);
    tick();
    bus.dram_valid = '0;
    sample();
    chk("rd_full_done", 64'(bus.rq0_done), 64'd1);
    tick();
    sample();
    chk("rd_full_done_pulse", 64'(bus.rq0_done), 64'd0);
    chk("rd_full_rdata_hold", bus.rq_rdata, exp_rdata(64'h0, 8'hFF));

    // Sparse mask with a spurious strobe outside the mask.
    tick();
    drive_req(1, 8'h05, 1'b0, 64'h40, 64'h0);
    sample();
    chk_grants("sparse", 1'b0, 1'b1);
    push_exp(1'b1, 1'b1, exp_rdata(64'h40, 8'h05));
    tick();
    bus.rq1_en = '0; bus.dram_valid = 8'h01;
    tick();
    bus.dram_valid = 8'h20;
    tick();
    bus.dram_valid = '0;
    tick();
    bus.dram_valid = 8'h04;
    sample();
    chk("sparse_early_done", 64'(bus.rq1_done), 64'd0);
    tick();
    bus.dram_valid = '0;
    sample();
    chk("sparse_done", 64'(bus.rq1_done), 64'd1);

    // Write; requester inputs change right after grant.
    tick();
    drive_req(0, 8'hFF, 1'b1, 64'h80, 64'hDEAD_BEEF_CAFE_F00D);
    sample();
    chk_grants("wr", 1'b1, 1'b0);
    push_exp(1'b0, 1'b0, 64'd0);
    tick();
    drive_req(0, 8'h00, 1'b0, 64'h999, 64'h5555);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("wr_hold_en", 64'(bus.dram_en), 64'hFF);
      chk("wr_hold_rdwr", 64'(bus.dram_rdwr), 64'd1);
      chk("wr_hold_wdata", bus.dram_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("wr_hold_addr5", bus.dram_addr[5], 64'h85);
      tick();
    end
    bus.dram_valid = 8'hFF;
    sample();
    chk("wr_early_done", 64'(bus.rq0_done), 64'd0);
    tick();
    bus.dram_valid = '0;
    sample();
    chk("wr_done", 64'(bus.rq0_done), 64'd1);

    // Reset mid-transaction with half the lanes returned.
    tick();
    drive_req(0, 8'hFF, 1'b0, 64'hC0, 64'h0);
    sample();
    chk_grants("abort", 1'b1, 1'b0);
    tick();
    bus.rq0_en = '0; bus.dram_valid = 8'h0F;
    tick();
    bus.dram_valid = '0; reset = 1'b1;
    tick();
    reset = 1'b0; bus.dram_valid = 8'hFF;
    sample();
    chk("abort_dram_en", 64'(bus.dram_en), 64'd0);
    chk("abort_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    chk("abort_no_done", {62'd0, bus.rq1_done, bus.rq0_done}, 64'd0);
    tick();
    bus.dram_valid = 8'hF0;
    sample();
    chk("abort_late_valid", {55'd0, bus.rq1_done, bus.rq0_done, bus.dram_en}, 64'd0);
    tick();
    bus.dram_valid = '0;
    drive_req(0, 8'h3C, 1'b0, 64'hE0, 64'h0);
    sample();
    chk_grants("after_abort", 1'b1, 1'b0);
    push_exp(1'b1, 1'b0, exp_rdata(64'hE0, 8'h3C));
    tick();
    bus.rq0_en = '0; bus.dram_valid = 8'h3C;
    tick();
    bus.dram_valid = '0;
    sample();
    chk("after_abort_done", 64'(bus.rq0_done), 64'd1);

    // No requests with random DRAM strobes.
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.dram_valid = 8'($urandom_range(0, 255));
      sample();
      chk("quiet_outs", {60'd0, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_done, bus.rq1_done}, 64'd0);
      chk("quiet_dram_en", 64'(bus.dram_en), 64'd0);
    end
    tick();
    bus.dram_valid = '0;
    repeat (3) tick();
    sample();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("n_gnt0", 64'(n_gnt0), 64'd6);
    chk("n_gnt1", 64'(n_gnt1), 64'd3);
    chk("n_done0", 64'(n_done0), 64'd5);
    chk("n_done1", 64'(n_done1), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 rq0_en  in  8  requester-0 lane enables; nonzero = request pending.
REQ-004 rq0_rdwr  in  1  requester-0 direction; passed to DRAM unchanged.
REQ-005 rq0_addr  in  8x64  requester-0 per-lane byte addresses.
REQ-006 rq0_data  in  64  requester-0 write data.
REQ-007 rq1_en / rq1_rdwr / rq1_addr / rq1_data  in  8 / 1 / 8x64 / 64  requester-1 equivalents.
REQ-008 rq0_gnt, rq1_gnt  out  1 each  one-cycle pulse: request latched.
REQ-009 rq0_done, rq1_done  out  1 each  one-cycle pulse: all enabled lanes returned.
REQ-010 rq_rdata  out  8x8  per-lane read bytes, shared by both requesters, valid while doneN is high.
REQ-011 dram_en  out  8  lane enables to DRAM.
REQ-012 dram_rdwr  out  1  direction to DRAM.
REQ-013 dram_addr  out  8x64  lane addresses to DRAM.
REQ-014 dram_wdata  out  64  write data to DRAM.
REQ-015 dram_rdata  in  8x8  DRAM per-lane read data.
REQ-016 dram_valid  in  8  DRAM per-lane completion strobes.

Function
REQ-017 FSM states: IDLE, BUSY; a registered owner bit records the granted requester.
REQ-018 In IDLE, request present when rqN_en != 0; an all-zero rqN_en is never a request.
REQ-019 Single request in IDLE at cycle N -> rqN_gnt high in cycle N; enable mask, rdwr, addr and data latched; state BUSY from N+1.
REQ-020 Both requesting in IDLE -> grant the requester NOT granted last; after reset, requester 0 wins the first tie.
REQ-021 In BUSY, dram_en/rdwr/addr/wdata driven from latched registers, held stable every cycle until completion.
REQ-022 In IDLE, dram_en = 0; dram_rdwr, dram_addr and dram_wdata = 0.
REQ-023 In BUSY, each cycle: for every lane with dram_valid=1 and its bit set in the latched mask, capture dram_rdata into the lane register and set the lane's returned bit.
REQ-024 dram_valid on lanes outside the latched mask, or in IDLE, is ignored.
REQ-025 Completion: cycle in which (returned | (dram_valid & mask)) == mask -> next cycle the owner's rqN_done pulses, rq_rdata shows all captured bytes, state returns to IDLE, and dram_en drops to 0.
REQ-026 The done cycle is spent in IDLE and may grant a new request in the same cycle; a transaction then costs ≥1 cycle of dram_en=0 between owners.
REQ-027 Requester inputs may change after gnt; they are not sampled in BUSY.
REQ-028 Requests arriving in BUSY wait without a gnt; the non-owner wins the next IDLE tie.
REQ-029 rq_rdata holds its last value outside done cycles; unenabled lanes read 0 for that transaction.
REQ-030 Write transactions (any rdwr) complete on dram_valid identically; rq_rdata content undefined for writes.

Reset
REQ-031 reset=1 at any edge: state IDLE, priority to requester 0, latched mask/returned/rdata = 0, all outputs 0 next cycle.
REQ-032 Reset mid-BUSY aborts the transaction with no done pulse; late dram_valid after reset is ignored.

Structure
REQ-033 Shared package holds NUM_LANES=8, lane_addr_t (8x64), lane_data_t (8x8) and the arbiter state enum.
REQ-034 No sub-module is required; arbitration and collection live in dram_arbiter.

Verification
REQ-035 rq0_en=8'hFF, addr lanes 0..7 = 0x0..0x7, DRAM valid 2 cycles later on all lanes -> rq0_gnt one pulse, rq0_done one pulse, rq_rdata = mem[0..7].
REQ-036 rq0 and rq1 both request in the first IDLE cycle after reset -> rq0 granted; rq1 granted on rq0's done cycle; on the next simultaneous request rq0 is granted.
REQ-037 rq1_en=8'h05, dram_valid lane 0 at t, lane 2 at t+3, spurious lane 5 at t+1 -> done one cycle after t+3, lanes 1,3-7 of rq_rdata = 0.
REQ-038 rq0_en changed to 8'h00 one cycle after gnt -> dram_en stays at latched 8'hFF until done.
REQ-039 reset pulsed while BUSY with 4 of 8 lanes returned -> no done, dram_en=0 next cycle, subsequent dram_valid ignored, next rq0 request served normally.
REQ-040 rq0_en=0 and rq1_en=0 for 10 cycles with random dram_valid -> no gnt, no done, dram_en=0 throughout.
